// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if: valid/ready word stream carrying one 512-bit chunk, W0 first
interface sha256_msg_schedule_if;
  logic [31:0] s_word;
  logic        s_valid;
  logic        s_ready;
  modport master (output s_word, s_valid, input s_ready);
  modport slave (input s_word, s_valid, output s_ready);
endinterface

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: loads a 16-word chunk and streams W[t]/K[t] plus round strobes to the compressor
// Optional SHA256_SCHED_BSWAP_EN byte-reverses each incoming word (little-endian memory feeds).
module sha256_msg_schedule (
  input  logic                        clk,
  input  logic                        rst,
  sha256_msg_schedule_if.slave        s,
  output logic [31:0]                 w_out,
  output logic [31:0]                 k_out,
  output logic                        compress_start,
  output logic                        update_hash,
  output logic                        chunk_done
);
  typedef enum logic [1:0] {LOAD, PRE, ROUND, FIN} state_t;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  state_t      state, state_nx;
  logic [31:0] win [16];
  logic [3:0]  idx;
  logic [6:0]  t;
  logic [5:0]  k_idx;
  logic [31:0] word, w_new, sig0, sig1;
  logic        accept, shift;
`ifdef SHA256_SCHED_BSWAP_EN
  assign word = {s.s_word[7:0], s.s_word[15:8], s.s_word[23:16], s.s_word[31:24]};
`else
  assign word = s.s_word;
`endif
  // win[0] is always W[t]; win[15] receives W[t+16] as the window slides
  assign sig0  = {win[1][6:0], win[1][31:7]} ^ {win[1][17:0], win[1][31:18]} ^ (win[1] >> 3);
  assign sig1  = {win[14][16:0], win[14][31:17]} ^ {win[14][18:0], win[14][31:19]} ^ (win[14] >> 10);
  assign w_new = sig1 + win[9] + sig0 + win[0];
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else state <= state_nx;
  end
  always_comb begin
    s.s_ready      = state == LOAD;
    accept         = state == LOAD && s.s_valid;
    shift          = state == PRE || (state == ROUND && t != 7'd64);
    compress_start = state == ROUND;
    update_hash    = state == ROUND && t == 7'd64;
    chunk_done     = state == FIN;
    k_idx          = state == ROUND ? t[5:0] : 6'd0;
    w_out          = shift ? win[0] : 32'd0;
    k_out          = shift ? K[k_idx] : 32'd0;
    state_nx       = state == LOAD  ? (accept && idx == 4'd15 ? PRE : LOAD) :
                     state == PRE   ? ROUND :
                     state == ROUND ? (t == 7'd64 ? FIN : ROUND) : LOAD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      t   <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      if (accept) begin
        win[idx] <= word;
        idx      <= idx + 4'd1;
      end
      if (shift) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
      end
      t <= state == PRE ? 7'd1 : state == ROUND ? t + 7'd1 : 7'd0;
    end
  end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: table-driven chunk vectors with a W/K scoreboard and digest reference checks
module tb_sha256_msg_schedule;
  logic        clk, rst;
  logic [31:0] w_out, k_out;
  logic        compress_start, update_hash, chunk_done;
  logic [3:0]  ctrl;
  sha256_msg_schedule_if bus ();
  sha256_msg_schedule dut (
    .clk(clk), .rst(rst), .s(bus.slave), .w_out(w_out), .k_out(k_out),
    .compress_start(compress_start), .update_hash(update_hash), .chunk_done(chunk_done)
  );
  assign ctrl = {bus.s_ready, compress_start, update_hash, chunk_done};
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic [31:0][31:0] msg;
    logic [1:0]        nchunk;
    logic [6:0]        gap_pct;
    logic              hold;
    logic [255:0]      digest;
  } vec_t;
  typedef struct packed {
    logic [5:0]  idx;
    logic        is_k;
    logic [31:0] val;
  } spot_t;

  vec_t        vt [4];
  spot_t       sp [4];
  logic [63:0] exp_q [$];
  logic [31:0] cw [64];
  logic [31:0] ck [64];
  logic [31:0] hs [8];
  logic [15:0][31:0] abc;
  int          n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] feed(input logic [31:0] w);
`ifdef SHA256_SCHED_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic reset_hash();
    hs = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  endtask

  // Reference SHA-256 compression driven by the W/K values the DUT actually emitted
  task automatic compress_chunk();
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};
    for (int r = 0; r < 64; r++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + ck[r] + cw[r];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hs[0] += a; hs[1] += b; hs[2] += c; hs[3] += d;
    hs[4] += e; hs[5] += f; hs[6] += g; hs[7] += h;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    bus.s_word  = feed(w);
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("s_ready timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle_watch(input int n, input string name);
    int bad = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (ctrl !== 4'b1000 || {w_out, k_out} !== 64'd0) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic run_chunk(input logic [15:0][31:0] m, input int gap_pct, input bit hold, input int abort_t);
    logic [31:0] w [64];
    logic [3:0]  ec;
    logic [63:0] ewk;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < 8 && int'($urandom_range(99)) < gap_pct; g++) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_word(m[i]);
    end
    bus.s_valid = hold;
    bus.s_word  = 32'hdeadbeef;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 64; i++) exp_q.push_back({w[i], KT[i]});
    exp_q.push_back(64'd0);
    // c=0 PRE, c=1..64 round t=c, c=65 FIN, c=66 back in LOAD
    for (int c = 0; c <= 66; c++) begin
      ec = c == 0 ? 4'b0000 : c < 64 ? 4'b0100 : c == 64 ? 4'b0110 : c == 65 ? 4'b0001 : 4'b1000;
      if (c == 65) bus.s_valid = 1'b0;
      check($sformatf("ctrl c%0d", c), ctrl, ec);
      if (c <= 64) begin
        ewk = exp_q.size() > 0 ? exp_q.pop_front() : 64'hffffffffffffffff;
        check($sformatf("w/k c%0d", c), {w_out, k_out}, ewk);
        if (c < 64) begin
          cw[c] = w_out;
          ck[c] = k_out;
        end
      end
      if (c == abort_t) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.s_valid = 1'b0;
        check("abort ctrl", ctrl, 4'b1000);
        check("abort w/k", {w_out, k_out}, 64'd0);
        exp_q.delete();
        return;
      end
      if (c < 66) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    abc = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    for (int v = 0; v < 4; v++) begin
      vt[v] = '0;
      vt[v].nchunk  = v < 2 ? 2'd1 : 2'd2;
      vt[v].gap_pct = v == 0 || v == 2 ? 7'd0 : 7'd40;
      vt[v].hold    = v == 1 || v == 3;
      vt[v].digest  = v < 2 ? 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad
                            : 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
      if (v < 2) vt[v].msg[15:0] = abc;
      else begin
        for (int i = 0; i < 14; i++) begin
          logic [7:0] b;
          b = 8'h61 + 8'(i);
          vt[v].msg[i] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
        end
        vt[v].msg[14] = 32'h80000000;
        vt[v].msg[31] = 32'h000001c0;
      end
    end
    sp[0] = '{6'd0,  1'b1, 32'h428a2f98};
    sp[1] = '{6'd16, 1'b0, 32'h61626380};
    sp[2] = '{6'd17, 1'b0, 32'h000f0000};
    sp[3] = '{6'd63, 1'b1, 32'hc67178f2};

    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_word  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ctrl", ctrl, 4'b1000);
    check("reset w/k", {w_out, k_out}, 64'd0);
    rst = 1'b0;
    idle_watch(100, "idle after reset");

    for (int v = 0; v < 4; v++) begin
      reset_hash();
      for (int c = 0; c < int'(vt[v].nchunk); c++) begin
        run_chunk(vt[v].msg[c*16 +: 16], int'(vt[v].gap_pct), vt[v].hold, -1);
        compress_chunk();
      end
      check($sformatf("vec%0d digest", v), {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]}, vt[v].digest);
      if (v == 0)
        for (int i = 0; i < 4; i++)
          check($sformatf("spot %s%0d", sp[i].is_k ? "k" : "w", sp[i].idx),
                sp[i].is_k ? ck[sp[i].idx] : cw[sp[i].idx], sp[i].val);
    end

    // Abort at round 30, then a clean chunk must still produce the right digest
    run_chunk(abc, 0, 1'b1, 30);
    idle_watch(70, "idle after abort");
    reset_hash();
    run_chunk(abc, 0, 1'b0, -1);
    compress_chunk();
    check("post-abort digest", {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]}, vt[0].digest);

    // Partial window, then reset coinciding with a valid word: neither may leak into the next chunk
    for (int i = 0; i < 5; i++) send_word(32'hffffffff);
    bus.s_word  = feed(32'h12345678);
    bus.s_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    check("rst+valid ctrl", ctrl, 4'b1000);
    reset_hash();
    run_chunk(abc, 20, 1'b0, -1);
    compress_chunk();
    check("post-partial digest", {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]}, vt[0].digest);

    check("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
